// File: rtl/maria_reg_sequencer.sv
// maria_reg_sequencer
//   Bus initiator for the MARIA register window BASE..BASE+31. Shares the
//   6502 bus through a req/grant handshake and issues one CPU-style access
//   per pclk_2 strobe. Used for savestate restore (write pass from a
//   32-byte buffer) and savestate dump (read pass into the buffer).
//
//   Optional build macro: MARIA_SEQ_VERIFY_EN
//     Adds a read-back pass after a write pass. Bytes read back are compared
//     against the buffer. Outputs verify_err / err_idx exist only in this build.
//
// Ports
//   sysclock, reset      system clock, synchronous active-high reset
//   start, mode, abort   pass control (mode 0 = write/restore, 1 = read/dump)
//   busy, done, aborted  pass status
//   buf_addr/rdata/wdata/we  32-byte buffer port (rdata one cycle after addr)
//   bus_req, bus_grant   arbiter handshake
//   pclk2_en             one-sysclock strobe on the pclk_2 rising edge
//   AB, DB_wr, DB_rd, we_b, drive_en  shared bus initiator signals
//   verify_err, err_idx  (MARIA_SEQ_VERIFY_EN only) read-back mismatch report
module maria_reg_sequencer #(
  parameter logic [15:0] BASE     = 16'h0020,
  parameter logic [31:0] WR_SKIP  = 32'h0100_0110,
  parameter logic [31:0] RD_SKIP  = 32'h0100_0010,
  parameter logic [4:0]  CTRL_IDX = 5'd28
) (
  input  logic        sysclock,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [4:0]  buf_addr,
  input  logic [7:0]  buf_rdata,
  output logic [7:0]  buf_wdata,
  output logic        buf_we,
  output logic        bus_req,
  input  logic        bus_grant,
  input  logic        pclk2_en,
  output logic [15:0] AB,
  output logic [7:0]  DB_wr,
  input  logic [7:0]  DB_rd,
  output logic        we_b,
  output logic        drive_en
`ifdef MARIA_SEQ_VERIFY_EN
  ,
  output logic        verify_err,
  output logic [4:0]  err_idx
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, FETCH, ACCESS, CAPTURE, NEXT, RELEASE} state_t;

  state_t      state;
  logic        mode_r;
  logic [4:0]  slot;
  logic        have_idx;
  logic        abort_pend;
  logic        fetch_wait;
  logic        vfy_phase;

  logic        plain;
  logic [4:0]  idx;
  logic [31:0] act_skip;
  logic [5:0]  first_slot;
  logic [5:0]  next_slot;
  logic        abort_now;
  logic        acc_rd;

`ifdef MARIA_SEQ_VERIFY_EN
  // Read-back covers written indices that are also readable; the
  // write-only registers at $2C, $30, $34 and $3C are excluded.
  localparam logic [31:0] VFY_SKIP = WR_SKIP | RD_SKIP | 32'h1011_1000;
  logic [7:0]  vfy_byte;
  logic [5:0]  vfy_first;
`else
  assign vfy_phase = 1'b0;
`endif

  // Slots are walked in ascending order. In the write order CTRL_IDX is
  // pulled out of its natural place and moved to the final slot so the
  // control register lands after the list pointers and colours.
  function automatic logic [4:0] slot_to_idx(input logic [4:0] s, input logic pl);
    logic [4:0] r;
    if (pl || s < CTRL_IDX) r = s;
    else if (s == 5'd31)    r = CTRL_IDX;
    else                    r = s + 5'd1;
    return r;
  endfunction

  // Returns {found, slot}: the lowest slot >= from whose index is not skipped.
  function automatic logic [5:0] find_slot(input logic [5:0] from,
                                           input logic [31:0] skip,
                                           input logic pl);
    logic [5:0] r;
    r = 6'd0;
    for (int k = 31; k >= 0; k--) begin
      if (6'(k) >= from && !skip[slot_to_idx(5'(k), pl)]) r = {1'b1, 5'(k)};
    end
    return r;
  endfunction

  always_comb begin
    plain      = mode_r | vfy_phase;
    acc_rd     = mode_r | vfy_phase;
    idx        = slot_to_idx(slot, plain);
    abort_now  = abort | abort_pend;
    first_slot = find_slot(6'd0, mode ? RD_SKIP : WR_SKIP, mode);
`ifdef MARIA_SEQ_VERIFY_EN
    act_skip   = vfy_phase ? VFY_SKIP : (mode_r ? RD_SKIP : WR_SKIP);
    vfy_first  = find_slot(6'd0, VFY_SKIP, 1'b1);
`else
    act_skip   = mode_r ? RD_SKIP : WR_SKIP;
`endif
    next_slot  = find_slot({1'b0, slot} + 6'd1, act_skip, plain);
  end

  // Single sequencer FSM; every output is registered here. An access only
  // counts on a pclk2_en strobe seen while granted and already driving, so a
  // dropped grant stalls the pass without losing or duplicating a cycle.
  always_ff @(posedge sysclock) begin
    if (reset) begin
      state      <= IDLE;
      mode_r     <= 1'b0;
      slot       <= 5'd0;
      have_idx   <= 1'b0;
      abort_pend <= 1'b0;
      fetch_wait <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      buf_addr   <= 5'd0;
      buf_wdata  <= 8'd0;
      buf_we     <= 1'b0;
      bus_req    <= 1'b0;
      AB         <= 16'd0;
      DB_wr      <= 8'd0;
      we_b       <= 1'b1;
      drive_en   <= 1'b0;
`ifdef MARIA_SEQ_VERIFY_EN
      vfy_phase  <= 1'b0;
      vfy_byte   <= 8'd0;
      verify_err <= 1'b0;
      err_idx    <= 5'd0;
`endif
    end else begin
      done   <= 1'b0;
      buf_we <= 1'b0;
      if (state != IDLE && abort) abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            mode_r     <= mode;
            slot       <= first_slot[4:0];
            have_idx   <= first_slot[5];
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
            fetch_wait <= 1'b0;
            busy       <= 1'b1;
            bus_req    <= 1'b1;
`ifdef MARIA_SEQ_VERIFY_EN
            vfy_phase  <= 1'b0;
            verify_err <= 1'b0;
            err_idx    <= 5'd0;
`endif
            state      <= REQ;
          end
        end

        REQ: begin
          if (abort_now) begin
            state <= RELEASE;
          end else if (bus_grant) begin
            if (have_idx) begin
              buf_addr <= idx;
              state    <= FETCH;
            end else begin
              state <= RELEASE;
            end
          end
        end

        // Write and verify passes spend two cycles here: one to present
        // buf_addr, one to take buf_rdata.
        FETCH: begin
          if (abort_now) begin
            fetch_wait <= 1'b0;
            state      <= RELEASE;
          end else if (bus_grant) begin
            if (!mode_r && !fetch_wait) begin
              fetch_wait <= 1'b1;
            end else begin
              fetch_wait <= 1'b0;
              if (!mode_r) begin
                if (vfy_phase) begin
`ifdef MARIA_SEQ_VERIFY_EN
                  vfy_byte <= buf_rdata;
`endif
                end else begin
                  DB_wr <= buf_rdata;
                end
              end
              AB       <= BASE + {11'd0, idx};
              drive_en <= 1'b1;
              we_b     <= acc_rd;
              state    <= ACCESS;
            end
          end
        end

        ACCESS: begin
          drive_en <= bus_grant;
          we_b     <= bus_grant ? acc_rd : 1'b1;
          if (pclk2_en && bus_grant && drive_en) begin
            if (acc_rd) begin
              state <= CAPTURE;
            end else begin
              drive_en <= 1'b0;
              we_b     <= 1'b1;
              state    <= NEXT;
            end
          end
        end

        // The responder registered DB_rd on the previous strobe; take it on
        // this one.
        CAPTURE: begin
          drive_en <= bus_grant;
          we_b     <= 1'b1;
          if (pclk2_en && bus_grant && drive_en) begin
            drive_en <= 1'b0;
            if (vfy_phase) begin
`ifdef MARIA_SEQ_VERIFY_EN
              if (DB_rd != vfy_byte && !verify_err) begin
                verify_err <= 1'b1;
                err_idx    <= idx;
              end
`endif
            end else begin
              buf_wdata <= DB_rd;
              buf_addr  <= idx;
              buf_we    <= 1'b1;
            end
            state <= NEXT;
          end
        end

        NEXT: begin
          if (abort_now) begin
            state <= RELEASE;
          end else if (next_slot[5]) begin
            slot     <= next_slot[4:0];
            buf_addr <= slot_to_idx(next_slot[4:0], plain);
            state    <= FETCH;
          end
`ifdef MARIA_SEQ_VERIFY_EN
          else if (!mode_r && !vfy_phase && vfy_first[5]) begin
            vfy_phase <= 1'b1;
            slot      <= vfy_first[4:0];
            buf_addr  <= vfy_first[4:0];
            state     <= FETCH;
          end
`endif
          else begin
            state <= RELEASE;
          end
        end

        RELEASE: begin
          drive_en <= 1'b0;
          we_b     <= 1'b1;
          bus_req  <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          aborted  <= abort_pend;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maria_reg_sequencer.sv
// tb_maria_reg_sequencer
//   Self-checking bench for maria_reg_sequencer. Models the 32-byte buffer
//   and the MARIA register responder; bus writes and buffer writes are
//   matched against scoreboard queues filled when each pass is launched.
module tb_maria_reg_sequencer;

  localparam logic [7:0] STATUS = 8'hA5;

  logic        sysclock = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [4:0]  buf_addr;
  logic [7:0]  buf_rdata;
  logic [7:0]  buf_wdata;
  logic        buf_we;
  logic        bus_req;
  logic        bus_grant;
  logic        pclk2_en;
  logic [15:0] AB;
  logic [7:0]  DB_wr;
  logic [7:0]  DB_rd;
  logic        we_b;
  logic        drive_en;
`ifdef MARIA_SEQ_VERIFY_EN
  logic        verify_err;
  logic [4:0]  err_idx;
`endif

  logic [7:0]  bufmem [32];
  logic [7:0]  regs   [32];
  logic        fill_en;
  logic [7:0]  fill_base;
  logic        corrupt;

  logic [23:0] wr_q [$];
  logic [12:0] rd_q [$];
  logic [23:0] exp_w;
  logic [12:0] exp_r;
  logic [23:0] last_wr;
  int          wr_count;
  int          bufwe_count;
  int          done_count;
  int          n_cmp;
  int          n_mis;
  int          ph;

  maria_reg_sequencer dut (
    .sysclock  (sysclock),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .buf_addr  (buf_addr),
    .buf_rdata (buf_rdata),
    .buf_wdata (buf_wdata),
    .buf_we    (buf_we),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .pclk2_en  (pclk2_en),
    .AB        (AB),
    .DB_wr     (DB_wr),
    .DB_rd     (DB_rd),
    .we_b      (we_b),
    .drive_en  (drive_en)
`ifdef MARIA_SEQ_VERIFY_EN
    ,
    .verify_err(verify_err),
    .err_idx   (err_idx)
`endif
  );

  always #5 sysclock = ~sysclock;

  // pclk_2 strobe: one sysclock in four, changed just after the rising edge.
  initial begin
    pclk2_en = 1'b0;
    ph = 0;
    forever begin
      @(posedge sysclock); #1;
      ph = (ph + 1) % 4;
      pclk2_en = (ph == 0);
    end
  end

  // Buffer RAM (registered read) and register responder. The status
  // register at index 8 returns a fixed value; index 15 can be corrupted.
  always @(posedge sysclock) begin
    if (fill_en) begin
      for (int i = 0; i < 32; i++) bufmem[i] <= fill_base + 8'(i);
    end else if (buf_we === 1'b1) begin
      bufmem[buf_addr] <= buf_wdata;
    end
    buf_rdata <= bufmem[buf_addr];
    if (pclk2_en && drive_en && AB[15:5] == 11'h001) begin
      if (!we_b) regs[AB[4:0]] <= DB_wr;
      else if (AB[4:0] == 5'd8) DB_rd <= STATUS;
      else if (corrupt && AB[4:0] == 5'd15) DB_rd <= ~regs[15];
      else DB_rd <= regs[AB[4:0]];
    end
  end

  // Scoreboard monitor, sampling mid-cycle what the next rising edge sees.
  initial begin
    forever begin
      @(negedge sysclock);
      if (pclk2_en === 1'b1 && drive_en === 1'b1 && we_b === 1'b0) begin
        wr_count++;
        last_wr = {AB, DB_wr};
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL bus_write: unexpected AB=%h DB=%h, none required", AB, DB_wr);
        end else begin
          exp_w = wr_q.pop_front();
          if ({AB, DB_wr} !== exp_w) begin
            n_mis++;
            $display("[TB] FAIL bus_write: got AB=%h DB=%h, required AB=%h DB=%h",
                     AB, DB_wr, exp_w[23:8], exp_w[7:0]);
          end
        end
      end
      if (buf_we === 1'b1) begin
        bufwe_count++;
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL buf_write: unexpected addr=%0d data=%h, none required", buf_addr, buf_wdata);
        end else begin
          exp_r = rd_q.pop_front();
          if ({buf_addr, buf_wdata} !== exp_r) begin
            n_mis++;
            $display("[TB] FAIL buf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     buf_addr, buf_wdata, exp_r[12:8], exp_r[7:0]);
          end
        end
      end
      if (done === 1'b1) done_count++;
    end
  end

  task automatic tick();
    @(posedge sysclock); #1;
  endtask

  task automatic fill_buffer(input logic [7:0] base);
    fill_base = base;
    fill_en = 1'b1;
    tick();
    fill_en = 1'b0;
  endtask

  task automatic start_pass(input logic m);
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Write order: ascending, skipping $24/$28/$38, CTRL ($3C) held back to last.
  task automatic push_write_pass(input int limit);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (i != 4 && i != 8 && i != 24 && i != 28 && n < limit) begin
        wr_q.push_back({16'h0020 + 16'(i), 8'h40 + 8'(i)});
        n++;
      end
    end
    if (n < limit) wr_q.push_back({16'h003C, 8'h5C});
  endtask

  task automatic wait_done(input int budget, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge sysclock);
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_mis++;
      $display("[TB] FAIL %s_done_timeout: done=0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    @(negedge sysclock);
    n_cmp++;
    if ({busy, done, aborted, buf_we, bus_req, drive_en} !== 6'b0) begin
      n_mis++;
      $display("[TB] FAIL reset_flags: got %b, required 000000",
               {busy, done, aborted, buf_we, bus_req, drive_en});
    end
    n_cmp++;
    if (we_b !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL reset_we_b: got %b, required 1", we_b);
    end
    n_cmp++;
    if ({AB, DB_wr, buf_addr, buf_wdata} !== 37'd0) begin
      n_mis++;
      $display("[TB] FAIL reset_busses: got AB=%h DB=%h addr=%0d wd=%h, required all 0",
               AB, DB_wr, buf_addr, buf_wdata);
    end
`ifdef MARIA_SEQ_VERIFY_EN
    n_cmp++;
    if (verify_err !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL reset_verify_err: got %b, required 0", verify_err);
    end
`endif
    @(posedge sysclock); #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_pass();
    int wc0, dc0;
    fill_buffer(8'h40);
    push_write_pass(32);
    wc0 = wr_count;
    dc0 = done_count;
    start_pass(1'b0);
    @(negedge sysclock);
    n_cmp++;
    if ({busy, bus_req} !== 2'b11) begin
      n_mis++;
      $display("[TB] FAIL wr_start_busy: got busy/req=%b, required 11", {busy, bus_req});
    end
    wait_done(3000, "wr");
    n_cmp++;
    if (aborted !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL wr_aborted: got %b, required 0", aborted);
    end
    repeat (4) tick();
    n_cmp++;
    if (wr_count - wc0 !== 29) begin
      n_mis++;
      $display("[TB] FAIL wr_count: got %0d writes, required 29", wr_count - wc0);
    end
    n_cmp++;
    if (last_wr !== {16'h003C, 8'h5C}) begin
      n_mis++;
      $display("[TB] FAIL wr_last: got %h, required 003c5c", last_wr);
    end
    n_cmp++;
    if (done_count - dc0 !== 1) begin
      n_mis++;
      $display("[TB] FAIL wr_done_pulses: got %0d, required 1", done_count - dc0);
    end
    n_cmp++;
    if (regs[0] !== 8'h40 || wr_q.size() != 0) begin
      n_mis++;
      $display("[TB] FAIL wr_color0: got %h (pending %0d), required 40 (pending 0)",
               regs[0], wr_q.size());
    end
    n_cmp++;
    if ({busy, bus_req, drive_en, we_b} !== 4'b0001) begin
      n_mis++;
      $display("[TB] FAIL wr_idle: got busy/req/drv/we_b=%b, required 0001",
               {busy, bus_req, drive_en, we_b});
    end
`ifdef MARIA_SEQ_VERIFY_EN
    n_cmp++;
    if (verify_err !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL wr_verify_clean: got %b, required 0", verify_err);
    end
`endif
  endtask

  task automatic test_read_pass();
    int bc0, wc0;
    fill_buffer(8'h80);
    for (int i = 0; i < 32; i++) begin
      if (i != 4 && i != 24)
        rd_q.push_back({5'(i), (i == 8) ? STATUS : 8'h40 + 8'(i)});
    end
    bc0 = bufwe_count;
    wc0 = wr_count;
    start_pass(1'b1);
    wait_done(3000, "rd");
    repeat (4) tick();
    n_cmp++;
    if (bufwe_count - bc0 !== 30 || rd_q.size() != 0) begin
      n_mis++;
      $display("[TB] FAIL rd_count: got %0d buf_we (pending %0d), required 30 (pending 0)",
               bufwe_count - bc0, rd_q.size());
    end
    n_cmp++;
    if (bufmem[0] !== 8'h40 || bufmem[8] !== STATUS) begin
      n_mis++;
      $display("[TB] FAIL rd_buffer: got [0]=%h [8]=%h, required 40 %h", bufmem[0], bufmem[8], STATUS);
    end
    n_cmp++;
    if (bufmem[4] !== 8'h84 || bufmem[24] !== 8'h98) begin
      n_mis++;
      $display("[TB] FAIL rd_skipped: got [4]=%h [24]=%h, required 84 98", bufmem[4], bufmem[24]);
    end
    n_cmp++;
    if (wr_count !== wc0) begin
      n_mis++;
      $display("[TB] FAIL rd_no_writes: got %0d bus writes, required 0", wr_count - wc0);
    end
  endtask

  task automatic test_grant_wait();
    int bad_drive, bad_req, wc0;
    logic seen;
    fill_buffer(8'h40);
    push_write_pass(32);
    bus_grant = 1'b0;
    wc0 = wr_count;
    bad_drive = 0;
    bad_req = 0;
    start_pass(1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge sysclock);
      if (drive_en !== 1'b0) bad_drive++;
      if (bus_req !== 1'b1) bad_req++;
      @(posedge sysclock); #1;
      start = (i == 10);
      mode = (i == 10);
    end
    start = 1'b0;
    mode = 1'b0;
    n_cmp++;
    if (bad_drive != 0 || bad_req != 0) begin
      n_mis++;
      $display("[TB] FAIL grant_hold: got %0d drive / %0d req violations, required 0 / 0",
               bad_drive, bad_req);
    end
    n_cmp++;
    if (wr_count !== wc0) begin
      n_mis++;
      $display("[TB] FAIL grant_no_access: got %0d writes before grant, required 0", wr_count - wc0);
    end
    bus_grant = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge sysclock);
      if (drive_en === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("[TB] FAIL grant_first_access: drive_en=0 20 cycles after grant, required 1");
    end
    wait_done(3000, "grant");
    repeat (2) tick();
    n_cmp++;
    if (wr_count - wc0 !== 29 || wr_q.size() != 0) begin
      n_mis++;
      $display("[TB] FAIL grant_writes: got %0d (pending %0d), required 29 (pending 0)",
               wr_count - wc0, wr_q.size());
    end
  endtask

  task automatic test_abort();
    int wc0;
    logic seen;
    push_write_pass(3);
    wc0 = wr_count;
    start_pass(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge sysclock);
      if (drive_en === 1'b1 && we_b === 1'b0 && AB === 16'h0022) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("[TB] FAIL abort_reach_third: third access never seen, required within 500 cycles");
    end
    @(posedge sysclock); #1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(500, "abort");
    n_cmp++;
    if ({aborted, bus_req, busy} !== 3'b100) begin
      n_mis++;
      $display("[TB] FAIL abort_done: got aborted/req/busy=%b, required 100", {aborted, bus_req, busy});
    end
    repeat (8) tick();
    n_cmp++;
    if (wr_count - wc0 !== 3 || wr_q.size() != 0) begin
      n_mis++;
      $display("[TB] FAIL abort_writes: got %0d (pending %0d), required 3 (pending 0)",
               wr_count - wc0, wr_q.size());
    end
    n_cmp++;
    if (aborted !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL abort_held: got %b, required 1", aborted);
    end
  endtask

  task automatic test_reset_capture();
    int bc0, wc0;
    logic seen;
    bc0 = bufwe_count;
    wc0 = wr_count;
    start_pass(1'b1);
    @(negedge sysclock);
    n_cmp++;
    if (aborted !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL start_clears_aborted: got %b, required 0", aborted);
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (i > 0) @(negedge sysclock);
      if (pclk2_en === 1'b1 && drive_en === 1'b1 && we_b === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("[TB] FAIL rstcap_reach: read strobe never seen, required within 200 cycles");
    end
    @(posedge sysclock); #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge sysclock);
    n_cmp++;
    if ({busy, drive_en, we_b, bus_req, buf_we} !== 5'b00100) begin
      n_mis++;
      $display("[TB] FAIL rstcap_outputs: got busy/drv/we_b/req/bwe=%b, required 00100",
               {busy, drive_en, we_b, bus_req, buf_we});
    end
    repeat (20) tick();
    n_cmp++;
    if (bufwe_count !== bc0 || wr_count !== wc0 || busy !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL rstcap_quiet: got %0d buf_we %0d writes busy=%b, required 0 0 0",
               bufwe_count - bc0, wr_count - wc0, busy);
    end
  endtask

`ifdef MARIA_SEQ_VERIFY_EN
  task automatic test_verify();
    fill_buffer(8'h40);
    push_write_pass(32);
    corrupt = 1'b1;
    start_pass(1'b0);
    @(negedge sysclock);
    n_cmp++;
    if (verify_err !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL vfy_start_clear: got %b, required 0", verify_err);
    end
    wait_done(4000, "vfy");
    n_cmp++;
    if (verify_err !== 1'b1 || err_idx !== 5'd15) begin
      n_mis++;
      $display("[TB] FAIL vfy_result: got err=%b idx=%0d, required 1 15", verify_err, err_idx);
    end
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_mis++;
      $display("[TB] FAIL vfy_writes: got %0d pending, required 0", wr_q.size());
    end
    corrupt = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_mis = 0;
    wr_count = 0;
    bufwe_count = 0;
    done_count = 0;
    last_wr = 24'd0;
    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    abort = 1'b0;
    bus_grant = 1'b1;
    fill_en = 1'b0;
    fill_base = 8'd0;
    corrupt = 1'b0;
    $display("[TB] starting maria_reg_sequencer bench");
    test_reset();
    test_write_pass();
    test_read_pass();
    test_grant_wait();
    test_abort();
    test_reset_capture();
`ifdef MARIA_SEQ_VERIFY_EN
    test_verify();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
